// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// controller state encoding and the alignment rule used at request accept.
// -----------------------------------------------------------------------------
package lsu_pkg;

   // Default number of word-index bits driven to the data memory
   localparam int WORD_IDX_W_DEF = 12;

   // Access size encodings as presented on req_size
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Controller states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      RMW_RD = 3'd2,
      WR     = 3'd3,
      ERR    = 3'd4
   } lsu_state_e;

   // A request is rejected when it is not naturally aligned for its size,
   // or when the size encoding is the reserved value.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addrLo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addrLo[0];
         SZ_WORD: bad = (addrLo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
//   word_i       : word read from data memory
//   wdata_i      : right-aligned store data (only byte/half stores use it)
//   addrLo_i     : byte offset within the word
//   size_i       : access size
//   unsigned_i   : zero-extend instead of sign-extend on sub-word loads
//   loadData_o   : selected lane, extended to 32 bits
//   mergedWord_o : word_i with the addressed store lanes replaced
// -----------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [15:0] wdata_i,
   input  logic [1:0]  addrLo_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] loadData_o,
   output logic [31:0] mergedWord_o
);

   logic [4:0]  bitOffset;
   logic [4:0]  halfOffset;
   logic [31:0] shifted;
   logic [31:0] laneMask;
   logic [31:0] laneData;

   // Little-endian lane selection: shift the addressed lane down to bit 0,
   // then extend from the lane's top bit unless a zero-extended load was asked.
   // Half loads are already known to be aligned, so the same shift serves.
   always_comb begin
      bitOffset  = {addrLo_i, 3'b000};
      shifted    = word_i >> bitOffset;
      loadData_o = word_i;
      case (size_i)
         SZ_BYTE: loadData_o = {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]};
         SZ_HALF: loadData_o = {{16{shifted[15] & ~unsigned_i}}, shifted[15:0]};
         default: loadData_o = word_i;
      endcase
   end

   // Read-modify-write merge: build a mask of the lanes being stored and
   // splice the shifted store data into the old word. Word stores never come
   // through here, so any other size leaves the old word untouched.
   always_comb begin
      halfOffset = {addrLo_i[1], 4'b0000};
      laneMask   = 32'h0000_0000;
      laneData   = 32'h0000_0000;
      case (size_i)
         SZ_BYTE: begin
            laneMask = 32'h0000_00FF << bitOffset;
            laneData = {24'h00_0000, wdata_i[7:0]} << bitOffset;
         end
         SZ_HALF: begin
            laneMask = 32'h0000_FFFF << halfOffset;
            laneData = {16'h0000, wdata_i} << halfOffset;
         end
         default: begin
            laneMask = 32'h0000_0000;
            laneData = 32'h0000_0000;
         end
      endcase
      mergedWord_o = (word_i & ~laneMask) | laneData;
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Converts byte-addressed byte/half/word load and store requests into accesses
// on a word-wide data memory that reads and writes on the falling clock edge.
// Sub-word stores use read-modify-write; loads are sign/zero extended;
// misaligned or illegal requests are answered with an error response.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid / req_ready    : request handshake (accept when both high)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                : request fields
//   resp_valid, resp_rdata,
//   resp_err                 : one-cycle completion pulse and its data/status
//   mem_write_en, mem_addr,
//   mem_write_data,
//   mem_read_data            : data memory interface (word-indexed)
// -----------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WORD_IDX_W = WORD_IDX_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_write_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   lsu_state_e              state_q, state_d;
   logic [1:0]              size_q;
   logic                    unsigned_q;
   logic [WORD_IDX_W+1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic                    respValid_q;
   logic                    respErr_q;
   logic [31:0]             respRdata_q;
   logic                    accept;
   logic [31:0]             loadData;
   logic [31:0]             mergedWord;
   logic                    unusedAddrBits;

   // Address bits above the memory's reach are dropped so accesses wrap
   assign unusedAddrBits = &{1'b0, req_addr[31:WORD_IDX_W+2]};

   assign accept = req_valid & req_ready;

   lsu_align u_align (
      .word_i       (mem_read_data),
      .wdata_i      (wdata_q[15:0]),
      .addrLo_i     (addr_q[1:0]),
      .size_i       (size_q),
      .unsigned_i   (unsigned_q),
      .loadData_o   (loadData),
      .mergedWord_o (mergedWord)
   );

   // State register; reset drops out of any access at once, which also
   // removes a pending write strobe before the memory can sample it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decision. The alignment check and the store/load split are
   // made from the live request at accept time; every other state lasts
   // exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  state_d = ERR;
               end else if (!req_we) begin
                  state_d = RD;
               end else if (req_size == SZ_WORD) begin
                  state_d = WR;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         RD:      state_d = IDLE;
         RMW_RD:  state_d = WR;
         WR:      state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and write strobe decode straight from the state so that the
   // strobe is valid for the whole WR cycle, including the falling edge.
   always_comb begin
      req_ready    = (state_q == IDLE);
      mem_write_en = (state_q == WR);
   end

   // Request capture plus the write-data register. The write-data register
   // holds the store data for word stores and is overwritten with the merged
   // word after the read half of a read-modify-write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         size_q     <= SZ_BYTE;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'h0000_0000;
      end else begin
         if (accept) begin
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr[WORD_IDX_W+1:0];
            wdata_q    <= req_wdata;
         end else if (state_q == RMW_RD) begin
            wdata_q    <= mergedWord;
         end
      end
   end

   // Response registers: a pulse leaves each terminal state (RD, WR, ERR);
   // only a completed load carries data, everything else reports zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         respValid_q <= 1'b0;
         respErr_q   <= 1'b0;
         respRdata_q <= 32'h0000_0000;
      end else begin
         respValid_q <= (state_q == RD) || (state_q == WR) || (state_q == ERR);
         respErr_q   <= (state_q == ERR);
         respRdata_q <= (state_q == RD) ? loadData : 32'h0000_0000;
      end
   end

   assign resp_valid     = respValid_q;
   assign resp_err       = respErr_q;
   assign resp_rdata     = respRdata_q;
   assign mem_addr       = {{(32 - WORD_IDX_W){1'b0}}, addr_q[WORD_IDX_W+1:2]};
   assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit with a negedge word memory and a
// byte-array reference model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_write_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   int passCount;
   int totalCount;
   int wrCount;
   logic memInit;

   logic [31:0] mem    [0:4095];
   logic [7:0]  refMem [0:16383];

   load_store_unit dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_write_en   (mem_write_en),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: registered read and write on the falling edge
   always @(negedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      end else if (mem_write_en && !rst) begin
         mem[mem_addr[11:0]] <= mem_write_data;
      end
      mem_read_data <= mem[mem_addr[11:0]];
   end

   // Count falling edges that see the write strobe
   always @(negedge clk) begin
      if (mem_write_en) wrCount <= wrCount + 1;
   end

   // Reference model: little-endian byte memory wrapping every 16 KB
   function automatic logic refErr(input logic [1:0] size, input logic [31:0] addr);
      int a;
      a = int'(addr % 32'd4);
      if (size == 2'd3) return 1'b1;
      if (size == 2'd1 && (a % 2) != 0) return 1'b1;
      if (size == 2'd2 && a != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] refLoad(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
      int a;
      logic [7:0]  b;
      logic [15:0] h;
      a = int'(addr % 32'd16384);
      if (size == 2'd0) begin
         b = refMem[a];
         return uns ? {24'h0, b} : {{24{b[7]}}, b};
      end else if (size == 2'd1) begin
         h = {refMem[a+1], refMem[a]};
         return uns ? {16'h0, h} : {{16{h[15]}}, h};
      end
      return {refMem[a+3], refMem[a+2], refMem[a+1], refMem[a]};
   endfunction

   task automatic refStore(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
      int a;
      int n;
      a = int'(addr % 32'd16384);
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      for (int i = 0; i < n; i++) refMem[a+i] = wdata[8*i +: 8];
   endtask

   function automatic logic [31:0] refWord(input int idx);
      return {refMem[4*idx+3], refMem[4*idx+2], refMem[4*idx+1], refMem[4*idx]};
   endfunction

   // Issue one request from idle and wait (bounded) for its response
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err,
                                output int lat, output int pulses,
                                output logic [31:0] addrSeen);
      int startPulses;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      startPulses = wrCount;
      @(posedge clk); #1;
      req_valid = 1'b0;
      addrSeen = mem_addr;
      lat = 0;
      while (lat < 8) begin
         @(posedge clk); #1;
         lat++;
         if (resp_valid) break;
      end
      if (!resp_valid) lat = -1;
      rdata  = resp_rdata;
      err    = resp_err;
      pulses = wrCount - startPulses;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if (req_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); else passCount++;
      totalCount++;
      if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); else passCount++;
      totalCount++;
      if (resp_rdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected 0", resp_rdata); else passCount++;
      totalCount++;
      if (resp_err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", resp_err); else passCount++;
      totalCount++;
      if (mem_write_en !== 1'b0) $display("[TB] FAIL reset_we: got %b expected 0", mem_write_en); else passCount++;
      totalCount++;
      if (mem_addr !== 32'h0) $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); else passCount++;
      totalCount++;
      if (mem_write_data !== 32'h0) $display("[TB] FAIL reset_wdata: got %h expected 0", mem_write_data); else passCount++;
      totalCount++;
      @(negedge clk);
      rst = 1'b0;
      memInit = 1'b0;
      @(posedge clk); #1;
      if (req_ready !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready); else passCount++;
      totalCount++;
   endtask

   task automatic test_word_store_load;
      logic [31:0] rd, as;
      logic err;
      int lat, pulses;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, rd, err, lat, pulses, as);
      refStore(2'b10, 32'h100, 32'hDEADBEEF);
      if (pulses !== 1) $display("[TB] FAIL word_store_pulses: got %0d expected 1", pulses); else passCount++;
      totalCount++;
      if (as !== 32'h40) $display("[TB] FAIL word_store_addr: got %h expected 00000040", as); else passCount++;
      totalCount++;
      if (lat !== 1) $display("[TB] FAIL word_store_latency: got %0d expected 1", lat); else passCount++;
      totalCount++;
      if (rd !== 32'h0 || err !== 1'b0) $display("[TB] FAIL word_store_resp: got %h/%b expected 0/0", rd, err); else passCount++;
      totalCount++;
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, err, lat, pulses, as);
      if (rd !== 32'hDEADBEEF) $display("[TB] FAIL word_load_data: got %h expected deadbeef", rd); else passCount++;
      totalCount++;
      if (err !== 1'b0) $display("[TB] FAIL word_load_err: got %b expected 0", err); else passCount++;
      totalCount++;
      if (lat !== 1) $display("[TB] FAIL word_load_latency: got %0d expected 1", lat); else passCount++;
      totalCount++;
      if (pulses !== 0) $display("[TB] FAIL word_load_pulses: got %0d expected 0", pulses); else passCount++;
      totalCount++;
   endtask

   task automatic test_subword_rmw;
      logic [31:0] rd, as;
      logic err;
      int lat, pulses;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, err, lat, pulses, as);
      refStore(2'b10, 32'h20, 32'h11223344);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, rd, err, lat, pulses, as);
      refStore(2'b00, 32'h22, 32'h000000AA);
      if (mem[8] !== 32'h11AA3344) $display("[TB] FAIL rmw_byte_word: got %h expected 11aa3344", mem[8]); else passCount++;
      totalCount++;
      if (lat !== 2) $display("[TB] FAIL rmw_byte_latency: got %0d expected 2", lat); else passCount++;
      totalCount++;
      if (pulses !== 1) $display("[TB] FAIL rmw_byte_pulses: got %0d expected 1", pulses); else passCount++;
      totalCount++;
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000BEEF, rd, err, lat, pulses, as);
      refStore(2'b01, 32'h20, 32'h0000BEEF);
      if (mem[8] !== 32'h11AABEEF) $display("[TB] FAIL rmw_half_word: got %h expected 11aabeef", mem[8]); else passCount++;
      totalCount++;
      if (lat !== 2) $display("[TB] FAIL rmw_half_latency: got %0d expected 2", lat); else passCount++;
      totalCount++;
      if (rd !== 32'h0 || err !== 1'b0) $display("[TB] FAIL rmw_half_resp: got %h/%b expected 0/0", rd, err); else passCount++;
      totalCount++;
   endtask

   task automatic test_extension;
      logic [31:0] rd, as;
      logic err;
      int lat, pulses;
      logic [1:0]  sizes [4];
      logic        unss  [4];
      logic [31:0] addrs [4];
      logic [31:0] exps  [4];
      sizes = '{2'b00, 2'b00, 2'b01, 2'b01};
      unss  = '{1'b0, 1'b1, 1'b0, 1'b1};
      addrs = '{32'h2, 32'h3, 32'h2, 32'h0};
      exps  = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0, 32'h80FF7F01, rd, err, lat, pulses, as);
      refStore(2'b10, 32'h0, 32'h80FF7F01);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, sizes[i], unss[i], addrs[i], 32'h0, rd, err, lat, pulses, as);
         if (rd !== exps[i] || err !== 1'b0)
            $display("[TB] FAIL ext_load_%0d: got %h/%b expected %h/0", i, rd, err, exps[i]);
         else passCount++;
         totalCount++;
      end
   endtask

   task automatic test_misaligned;
      logic [31:0] rd, as;
      logic err;
      int lat, pulses;
      logic        wes   [3];
      logic [1:0]  sizes [3];
      logic [31:0] addrs [3];
      wes   = '{1'b0, 1'b1, 1'b1};
      sizes = '{2'b01, 2'b10, 2'b11};
      addrs = '{32'h101, 32'h102, 32'h0};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(wes[i], sizes[i], 1'b0, addrs[i], 32'hCAFEF00D, rd, err, lat, pulses, as);
         if (err !== 1'b1 || rd !== 32'h0)
            $display("[TB] FAIL misalign_resp_%0d: got %h/%b expected 0/1", i, rd, err);
         else passCount++;
         totalCount++;
         if (pulses !== 0 || lat !== 1)
            $display("[TB] FAIL misalign_access_%0d: got pulses %0d lat %0d expected 0/1", i, pulses, lat);
         else passCount++;
         totalCount++;
      end
      if (mem[16'h40] !== 32'hDEADBEEF) $display("[TB] FAIL misalign_mem40: got %h expected deadbeef", mem[16'h40]); else passCount++;
      totalCount++;
      if (mem[0] !== 32'h80FF7F01) $display("[TB] FAIL misalign_mem0: got %h expected 80ff7f01", mem[0]); else passCount++;
      totalCount++;
   endtask

   task automatic test_random;
      logic [31:0] rd, as, addr, wdata, expRd;
      logic err, we, uns, expErr;
      logic [1:0] size;
      int lat, pulses, expLat;
      for (int n = 0; n < 60; n++) begin
         we    = 1'($urandom_range(0, 1));
         size  = 2'($urandom_range(0, 3));
         uns   = 1'($urandom_range(0, 1));
         addr  = $urandom & 32'hFFFF_C03F;
         wdata = $urandom;
         expErr = refErr(size, addr);
         expRd  = (expErr || we) ? 32'h0 : refLoad(size, uns, addr);
         expLat = (!expErr && we && size != 2'b10) ? 2 : 1;
         applyStimulus(we, size, uns, addr, wdata, rd, err, lat, pulses, as);
         if (we && !expErr) refStore(size, addr, wdata);
         if (rd !== expRd || err !== expErr || lat !== expLat ||
             pulses !== ((we && !expErr) ? 1 : 0) || as !== {20'h0, addr[13:2]})
            $display("[TB] FAIL random_%0d: got rd %h err %b lat %0d wr %0d addr %h expected rd %h err %b lat %0d",
                     n, rd, err, lat, pulses, as, expRd, expErr, expLat);
         else passCount++;
         totalCount++;
      end
      for (int i = 0; i < 16; i++) begin
         if (mem[i] !== refWord(i))
            $display("[TB] FAIL random_mem_%0d: got %h expected %h", i, mem[i], refWord(i));
         else passCount++;
         totalCount++;
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] addrs [3];
      int acceptCyc [3];
      int nAcc, nResp, cyc;
      logic rdyNow;
      logic [31:0] expRd;
      addrs = '{32'h4000, 32'h4, 32'h8};
      nAcc = 0; nResp = 0; cyc = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = addrs[0];
      while ((nAcc < 3 || nResp < 3) && cyc < 20) begin
         rdyNow = req_ready;
         @(posedge clk); #1;
         cyc++;
         if (resp_valid) begin
            expRd = refLoad(2'b10, 1'b0, addrs[nResp]);
            if (resp_rdata !== expRd || resp_err !== 1'b0)
               $display("[TB] FAIL b2b_data_%0d: got %h/%b expected %h/0", nResp, resp_rdata, resp_err, expRd);
            else passCount++;
            totalCount++;
            nResp++;
         end
         if (rdyNow && req_valid) begin
            acceptCyc[nAcc] = cyc;
            if (nAcc == 0) begin
               if (mem_addr !== 32'h0) $display("[TB] FAIL b2b_alias_addr: got %h expected 0", mem_addr); else passCount++;
               totalCount++;
               if (req_ready !== 1'b0) $display("[TB] FAIL b2b_ready_in_rd: got %b expected 0", req_ready); else passCount++;
               totalCount++;
            end
            nAcc++;
            if (nAcc < 3) req_addr = addrs[nAcc];
            else req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      if (nAcc < 3 || nResp < 3) begin
         $display("[TB] FAIL b2b_timeout: got %0d accepts %0d responses expected 3/3", nAcc, nResp);
         totalCount++;
      end else begin
         if (acceptCyc[1] - acceptCyc[0] !== 2 || acceptCyc[2] - acceptCyc[1] !== 2)
            $display("[TB] FAIL b2b_spacing: got %0d,%0d,%0d expected spacing 2", acceptCyc[0], acceptCyc[1], acceptCyc[2]);
         else passCount++;
         totalCount++;
      end
   endtask

   task automatic test_reset_mid_rmw;
      logic [31:0] rd, as;
      logic err;
      int lat, pulses;
      int respSeen;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, rd, err, lat, pulses, as);
      refStore(2'b10, 32'h30, 32'h12345678);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h31; req_wdata = 32'h99;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      if (mem_write_en !== 1'b1) $display("[TB] FAIL midrst_we_before: got %b expected 1", mem_write_en); else passCount++;
      totalCount++;
      rst = 1'b1;
      #1;
      if (mem_write_en !== 1'b0) $display("[TB] FAIL midrst_we_drop: got %b expected 0", mem_write_en); else passCount++;
      totalCount++;
      if (mem_addr !== 32'h0 || mem_write_data !== 32'h0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0)
         $display("[TB] FAIL midrst_outputs: got addr %h wdata %h valid %b err %b rdata %h expected all 0",
                  mem_addr, mem_write_data, resp_valid, resp_err, resp_rdata);
      else passCount++;
      totalCount++;
      @(posedge clk); #1;
      rst = 1'b0;
      if (req_ready !== 1'b1) $display("[TB] FAIL midrst_ready: got %b expected 1", req_ready); else passCount++;
      totalCount++;
      respSeen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (resp_valid) respSeen++;
      end
      if (respSeen !== 0) $display("[TB] FAIL midrst_no_resp: got %0d responses expected 0", respSeen); else passCount++;
      totalCount++;
      if (mem[12] !== refWord(12)) $display("[TB] FAIL midrst_mem: got %h expected %h", mem[12], refWord(12)); else passCount++;
      totalCount++;
   endtask

   initial begin
      passCount = 0; totalCount = 0; wrCount = 0;
      memInit = 1'b1;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < 16384; i++) refMem[i] = 8'h00;
      test_reset();
      test_word_store_load();
      test_subword_rmw();
      test_extension();
      test_misaligned();
      test_random();
      test_back_to_back();
      test_reset_mid_rmw();
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
